// File: rtl/datapath_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_core_if
//  Description : Bundles the counter, ALU and decoder signals of datapath_core.
//                The master drives the controls and operands; the slave is the
//                datapath itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface datapath_core_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 cnt_ce;
   logic                 cnt_load;
   logic [CNT_WIDTH-1:0] cnt_preset;
   logic [CNT_WIDTH-1:0] cnt_out;

   logic                 alu_mode;
   logic [3:0]           alu_op;
   logic                 alu_c_in;
   logic [15:0]          alu_x;
   logic [15:0]          alu_y;
   logic [15:0]          alu_z;
   logic                 alu_c_out;

   logic [2:0]           dmx_sel;
   logic [7:0]           dmx_y;

   modport master (
      output cnt_ce, cnt_load, cnt_preset,
      output alu_mode, alu_op, alu_c_in, alu_x, alu_y,
      output dmx_sel,
      input  cnt_out, alu_z, alu_c_out, dmx_y
   );

   modport slave (
      input  cnt_ce, cnt_load, cnt_preset,
      input  alu_mode, alu_op, alu_c_in, alu_x, alu_y,
      input  dmx_sel,
      output cnt_out, alu_z, alu_c_out, dmx_y
   );
endinterface
`default_nettype wire

// File: rtl/datapath_core.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_core
//  Description : Loadable up-counter, 16-bit 74181-style ALU (17-bit sum with
//                carry-out) and a 3-to-8 active-low decoder.  Only the counter
//                holds state; the ALU and decoder are purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_core #(
   parameter int CNT_WIDTH = 16
) (
   input  wire logic        clk,
   input  wire logic        reset,
   datapath_core_if.slave   bus
);

   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [16:0]          C_MINUS_1  = 17'h0FFFF;

   logic [CNT_WIDTH-1:0] r_cnt;

   // Counter: reset beats load, load beats increment; increment wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (bus.cnt_load) begin
         r_cnt <= bus.cnt_preset;
      end else if (bus.cnt_ce) begin
         r_cnt <= r_cnt + C_CNT_ONE;
      end
   end

   assign bus.cnt_out = r_cnt;

   // Operands zero-extended to 17 bits so bit 16 of the sum is the carry-out.
   logic [16:0] w_a;
   logic [16:0] w_b;
   logic [16:0] w_nb;
   logic [16:0] w_p;
   logic [16:0] w_q;
   logic [16:0] w_sum;
   logic [15:0] w_logic;

   assign w_a  = {1'b0, bus.alu_x};
   assign w_b  = {1'b0, bus.alu_y};
   assign w_nb = {1'b0, ~bus.alu_y};

   // Arithmetic mode: each function is the sum of two selected terms; a "-1"
   // term is FFFF so that A-B-1 becomes A + ~B with the 74181 carry behaviour.
   always_comb begin
      w_p = '0;
      w_q = '0;
      case (bus.alu_op)
         4'h0: begin w_p = w_a;          w_q = '0;          end
         4'h1: begin w_p = w_a | w_b;    w_q = '0;          end
         4'h2: begin w_p = w_a | w_nb;   w_q = '0;          end
         4'h3: begin w_p = C_MINUS_1;    w_q = '0;          end
         4'h4: begin w_p = w_a;          w_q = w_a & w_nb;  end
         4'h5: begin w_p = w_a | w_b;    w_q = w_a & w_nb;  end
         4'h6: begin w_p = w_a;          w_q = w_nb;        end
         4'h7: begin w_p = w_a & w_nb;   w_q = C_MINUS_1;   end
         4'h8: begin w_p = w_a;          w_q = w_a & w_b;   end
         4'h9: begin w_p = w_a;          w_q = w_b;         end
         4'hA: begin w_p = w_a | w_nb;   w_q = w_a & w_b;   end
         4'hB: begin w_p = w_a & w_b;    w_q = C_MINUS_1;   end
         4'hC: begin w_p = w_a;          w_q = w_a;         end
         4'hD: begin w_p = w_a | w_b;    w_q = w_a;         end
         4'hE: begin w_p = w_a | w_nb;   w_q = w_a;         end
         default: begin w_p = w_a;       w_q = C_MINUS_1;   end
      endcase
   end

   assign w_sum = w_p + w_q + {16'd0, bus.alu_c_in};

   // Logic mode: bitwise functions of A and B, no carry involvement.
   always_comb begin
      w_logic = '0;
      case (bus.alu_op)
         4'h0:    w_logic = ~bus.alu_x;
         4'h1:    w_logic = ~(bus.alu_x | bus.alu_y);
         4'h2:    w_logic = ~bus.alu_x & bus.alu_y;
         4'h3:    w_logic = 16'h0000;
         4'h4:    w_logic = ~(bus.alu_x & bus.alu_y);
         4'h5:    w_logic = ~bus.alu_y;
         4'h6:    w_logic = bus.alu_x ^ bus.alu_y;
         4'h7:    w_logic = bus.alu_x & ~bus.alu_y;
         4'h8:    w_logic = ~bus.alu_x | bus.alu_y;
         4'h9:    w_logic = ~(bus.alu_x ^ bus.alu_y);
         4'hA:    w_logic = bus.alu_y;
         4'hB:    w_logic = bus.alu_x & bus.alu_y;
         4'hC:    w_logic = 16'hFFFF;
         4'hD:    w_logic = bus.alu_x | ~bus.alu_y;
         4'hE:    w_logic = bus.alu_x | bus.alu_y;
         default: w_logic = bus.alu_x;
      endcase
   end

   assign bus.alu_z     = bus.alu_mode ? w_logic : w_sum[15:0];
   assign bus.alu_c_out = bus.alu_mode ? 1'b0    : w_sum[16];

   logic [7:0] w_dmx;

   // Decoder: exactly one active-low output, selected by dmx_sel.
   always_comb begin
      w_dmx              = 8'hFF;
      w_dmx[bus.dmx_sel] = 1'b0;
   end

   assign bus.dmx_y = w_dmx;

endmodule
`default_nettype wire

// File: tb/tb_datapath_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_core
//  Description : Self-checking bench for datapath_core: directed vectors with
//                literal expectations, then randomized traffic compared every
//                cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_core;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   datapath_core_if #(.CNT_WIDTH(16)) bus ();

   datapath_core #(.CNT_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ALU reference written directly from the function tables.
   function automatic logic [16:0] alu_model(input logic mode, input logic [3:0] op,
                                             input logic c, input logic [15:0] x,
                                             input logic [15:0] y);
      int unsigned a, b, nb, r;
      logic [31:0] rv;
      a  = x;
      b  = y;
      nb = 32'hFFFF - b;
      r  = 0;
      if (mode) begin
         case (op)
            4'h0: r = ~a;
            4'h1: r = ~(a | b);
            4'h2: r = ~a & b;
            4'h3: r = 0;
            4'h4: r = ~(a & b);
            4'h5: r = ~b;
            4'h6: r = a ^ b;
            4'h7: r = a & ~b;
            4'h8: r = ~a | b;
            4'h9: r = ~(a ^ b);
            4'hA: r = b;
            4'hB: r = a & b;
            4'hC: r = 32'hFFFF;
            4'hD: r = a | nb;
            4'hE: r = a | b;
            default: r = a;
         endcase
         r = r & 32'hFFFF;
      end else begin
         case (op)
            4'h0: r = a;
            4'h1: r = a | b;
            4'h2: r = a | nb;
            4'h3: r = 32'hFFFF;
            4'h4: r = a + (a & nb);
            4'h5: r = (a | b) + (a & nb);
            4'h6: r = a + nb;
            4'h7: r = (a & nb) + 32'hFFFF;
            4'h8: r = a + (a & b);
            4'h9: r = a + b;
            4'hA: r = (a | nb) + (a & b);
            4'hB: r = (a & b) + 32'hFFFF;
            4'hC: r = a + a;
            4'hD: r = (a | b) + a;
            4'hE: r = (a | nb) + a;
            default: r = a + 32'hFFFF;
         endcase
         r = r + c;
      end
      rv = r;
      return rv[16:0];
   endfunction

   // Counter reference: valid only once a reset edge has been seen.
   logic [15:0] m_cnt   = '0;
   logic        m_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt   <= 16'd0;
         m_valid <= 1'b1;
      end else if (bus.cnt_load) begin
         m_cnt <= bus.cnt_preset;
      end else if (bus.cnt_ce) begin
         m_cnt <= m_cnt + 16'd1;
      end
   end

   // Compare every output against the model on the falling edge.
   always @(negedge clk) begin
      logic [16:0] e;
      e = alu_model(bus.alu_mode, bus.alu_op, bus.alu_c_in, bus.alu_x, bus.alu_y);
      if (m_valid) check("model_cnt", {16'd0, bus.cnt_out}, {16'd0, m_cnt});
      check("model_alu_z", {16'd0, bus.alu_z}, {16'd0, e[15:0]});
      check("model_alu_c", {31'd0, bus.alu_c_out}, {31'd0, e[16]});
      check("model_dmx", {24'd0, bus.dmx_y}, {24'd0, ~(8'h01 << bus.dmx_sel)});
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic alu_vec(input string name, input logic mode, input logic [3:0] op,
                          input logic c, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] ez, input logic ec);
      bus.alu_mode = mode;
      bus.alu_op   = op;
      bus.alu_c_in = c;
      bus.alu_x    = x;
      bus.alu_y    = y;
      #1;
      check({name, "_z"}, {16'd0, bus.alu_z}, {16'd0, ez});
      check({name, "_c"}, {31'd0, bus.alu_c_out}, {31'd0, ec});
   endtask

   logic [7:0] dmx_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      bus.cnt_ce     = 1'b1;
      bus.cnt_load   = 1'b1;
      bus.cnt_preset = 16'h55AA;
      bus.alu_mode   = 1'b0;
      bus.alu_op     = 4'h9;
      bus.alu_c_in   = 1'b0;
      bus.alu_x      = 16'h00FF;
      bus.alu_y      = 16'h0001;
      bus.dmx_sel    = 3'd0;

      // Reset wins over load and enable.
      tick();
      check("reset_cnt", {16'd0, bus.cnt_out}, 32'h0);
      reset        = 1'b0;
      bus.cnt_load = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("count_up", {16'd0, bus.cnt_out}, i);
      end
      bus.cnt_load   = 1'b1;
      bus.cnt_preset = 16'h1234;
      tick();
      check("load_over_ce", {16'd0, bus.cnt_out}, 32'h1234);
      bus.cnt_load = 1'b0;
      bus.cnt_ce   = 1'b0;
      tick();
      check("hold", {16'd0, bus.cnt_out}, 32'h1234);

      // Wrap at all-ones.
      bus.cnt_load   = 1'b1;
      bus.cnt_preset = 16'hFFFF;
      tick();
      check("load_ffff", {16'd0, bus.cnt_out}, 32'hFFFF);
      bus.cnt_load = 1'b0;
      bus.cnt_ce   = 1'b1;
      tick();
      check("wrap", {16'd0, bus.cnt_out}, 32'h0);
      bus.cnt_ce = 1'b0;
      tick();
      check("wrap_hold", {16'd0, bus.cnt_out}, 32'h0);

      // ALU literal vectors.
      alu_vec("add",      1'b0, 4'h9, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0);
      alu_vec("add_cy",   1'b0, 4'h9, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
      alu_vec("sub",      1'b0, 4'h6, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1);
      alu_vec("m1_cin",   1'b0, 4'h3, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b1);
      alu_vec("dec",      1'b0, 4'hF, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
      alu_vec("log_and",  1'b1, 4'hB, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0);
      alu_vec("log_or",   1'b1, 4'hE, 1'b1, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0);
      alu_vec("log_xor",  1'b1, 4'h6, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0);
      alu_vec("log_nota", 1'b1, 4'h0, 1'b0, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0);
      alu_vec("log_zero", 1'b1, 4'h3, 1'b0, 16'hF0F0, 16'hFF00, 16'h0000, 1'b0);
      alu_vec("log_ones", 1'b1, 4'hC, 1'b0, 16'hF0F0, 16'hFF00, 16'hFFFF, 1'b0);

      // Decoder sweep.
      for (int i = 0; i < 8; i++) begin
         bus.dmx_sel = 3'(i);
         #1;
         check("dmx_sweep", {24'd0, bus.dmx_y}, {24'd0, dmx_tab[i]});
      end

      // Reset mid-count at 5 while load and enable are both high.
      alu_vec("mid_alu", 1'b0, 4'h9, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0);
      bus.dmx_sel    = 3'd3;
      bus.cnt_load   = 1'b1;
      bus.cnt_preset = 16'h0003;
      bus.cnt_ce     = 1'b0;
      tick();
      bus.cnt_load = 1'b0;
      bus.cnt_ce   = 1'b1;
      tick();
      tick();
      check("mid_five", {16'd0, bus.cnt_out}, 32'h5);
      reset          = 1'b1;
      bus.cnt_load   = 1'b1;
      bus.cnt_preset = 16'h7777;
      tick();
      check("mid_reset", {16'd0, bus.cnt_out}, 32'h0);
      check("mid_rst_z", {16'd0, bus.alu_z}, 32'h0100);
      check("mid_rst_dmx", {24'd0, bus.dmx_y}, 32'hF7);
      reset        = 1'b0;
      bus.cnt_load = 1'b0;
      tick();
      check("mid_resume", {16'd0, bus.cnt_out}, 32'h1);
      check("mid_after_dmx", {24'd0, bus.dmx_y}, 32'hF7);

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         tick();
         reset          = ($urandom_range(0, 31) == 0);
         bus.cnt_load   = ($urandom_range(0, 7) == 0);
         bus.cnt_ce     = $urandom_range(0, 1) != 0;
         bus.cnt_preset = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         bus.alu_mode   = $urandom_range(0, 1) != 0;
         bus.alu_op     = 4'($urandom);
         bus.alu_c_in   = $urandom_range(0, 1) != 0;
         bus.alu_x      = 16'($urandom);
         bus.alu_y      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         bus.dmx_sel    = 3'($urandom);
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/datapath_core.md
DATAPATH_CORE -- requirements
Module: datapath_core

Interface
- REQ-001 SHALL have parameter CNT_WIDTH, default 16, which sets the counter width (legal range 2..16).
- REQ-002 clk  input  1  single clock; all state updates on its rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 cnt_ce  input  1  counter count enable.
- REQ-005 cnt_load  input  1  synchronous counter load strobe.
- REQ-006 cnt_preset  input  CNT_WIDTH  counter load value.
- REQ-007 cnt_out  output  CNT_WIDTH  counter state, driven directly from the register.
- REQ-008 alu_mode  input  1  ALU mode: 0 = arithmetic, 1 = logic.
- REQ-009 alu_op  input  4  ALU function select S[3:0].
- REQ-010 alu_c_in  input  1  arithmetic carry-in (1 = add one).
- REQ-011 alu_x, alu_y  input  16 each  ALU operands A and B.
- REQ-012 alu_z  output  16  ALU result; purely combinational.
- REQ-013 alu_c_out  output  1  carry-out of the arithmetic result (bit 16 of the 17-bit sum); 0 in logic mode.
- REQ-014 dmx_sel  input  3  decoder select.
- REQ-015 dmx_y  output  8  decoder outputs, active-low; combinational.

Function
- REQ-016 Counter priority at each rising edge SHALL be: reset -> 0; else cnt_load -> cnt_preset; else cnt_ce -> cnt_out+1 modulo 2^CNT_WIDTH; else hold.
- REQ-017 When cnt_load and cnt_ce are both 1, the counter SHALL load cnt_preset and SHALL NOT increment in that cycle.
- REQ-018 At the all-ones value, an increment SHALL wrap the counter to 0 with no other side effect.
- REQ-019 The counter load SHALL take effect one cycle after the strobe: cnt_out shows cnt_preset after the edge that samples cnt_load.
- REQ-020 In logic mode (alu_mode=1), alu_op 0..F SHALL select, in order: ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, FFFF, A|~B, A|B, A.
- REQ-021 In arithmetic mode (alu_mode=0), alu_op 0..F SHALL select, in order: A, A|B, A|~B, -1, A+(A&~B), (A|B)+(A&~B), A-B-1, (A&~B)-1, A+(A&B), A+B, (A|~B)+(A&B), (A&B)-1, A+A, (A|B)+A, (A|~B)+A, A-1.
- REQ-022 In arithmetic mode, alu_c_in SHALL be added to the selected result.
- REQ-023 The ALU SHALL compute arithmetic results in 17 bits: alu_z is bits 15:0 and alu_c_out is bit 16, where "-1" terms are two's-complement FFFF added into the sum.
- REQ-024 The ALU and the decoder SHALL contain no state and SHALL be unaffected by clk and reset.
- REQ-025 The decoder SHALL drive dmx_y[dmx_sel] to 0 and all other bits to 1; it has no enable, so exactly one output is low at all times.

Reset
- REQ-026 While reset=1 at a rising edge, cnt_out SHALL become 0, regardless of cnt_load and cnt_ce.
- REQ-027 Reset asserted mid-count SHALL clear cnt_out on that same edge, and counting SHALL resume from 0 on the first edge after release when cnt_ce=1.
- REQ-028 Before the first reset edge, cnt_out is unspecified.
- REQ-029 The combinational outputs (alu_z, alu_c_out, dmx_y) SHALL remain valid during reset.

Verification
- REQ-030 Counter sequence: reset 1 cycle, then cnt_ce=1 for 3 edges -> cnt_out = 0, 1, 2, 3; then cnt_load=1 with cnt_preset=0x1234 and cnt_ce=1 -> 0x1234 (no increment that cycle).
- REQ-031 Counter wrap: preset 0xFFFF, then cnt_ce=1 for 1 edge -> cnt_out=0x0000; cnt_ce=0 -> holds.
- REQ-032 ALU arithmetic:
  - mode=0, op=9, x=0x00FF, y=0x0001, c_in=0 -> z=0x0100, c_out=0.
  - x=0xFFFF, y=0x0001 -> z=0x0000, c_out=1.
  - op=6, c_in=1, x=5, y=3 -> z=0x0002.
- REQ-033 ALU logic: mode=1, x=0xF0F0, y=0xFF00:
  - op=B -> 0xF000.
  - op=E -> 0xFFF0.
  - op=6 -> 0x0FF0.
  - op=0 -> 0x0F0F.
  - op=3 -> 0x0000.
  - op=C -> 0xFFFF.
- REQ-034 Decoder: sweep dmx_sel 0..7 -> dmx_y = FE, FD, FB, F7, EF, DF, BF, 7F.
- REQ-035 Reset mid-count at cnt_out=5 with cnt_load=1 and cnt_ce=1 -> 0 next edge; decoder and ALU outputs unchanged throughout.
